exu_alu_arb: RTL and testbench

- Shares the single combinational ALU datapath (exu_alu_calc) between N_REQ requesters, e.g. the issue-slot ALU op, the branch compare and the LSU address add.
- Each cycle it picks one valid requester, round-robin, and encodes that requester's op into the ALU's per-function info buses. Buses for unused functions are zero, so the OR-merged ALU result stays clean.
- It registers the ALU result and compare flags into a one-entry response slot with a valid/ready handshake, tagged with the requester id.

---
 rtl/exu_alu_pkg.sv | 28 ++
 rtl/exu_alu_rr_pick.sv | 37 +++
 rtl/exu_alu_arb.sv | 190 +++++++++++++++++++
 tb/tb_exu_alu_arb.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_alu_pkg.sv
// exu_alu_pkg: the ALU op codes and the width constants shared by the
// ALU, its arbiter and the requesters.
package exu_alu_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  // Info-bus widths: {cin|sel, in2, in1}, {in2, in1}, {shamt, in1}
  localparam int ADD_INFO_W = 2 * XLEN + 1;
  localparam int LOG_INFO_W = 2 * XLEN;
  localparam int SHF_INFO_W = XLEN + SHAMT_W;
  localparam int SLT_INFO_W = 2 * XLEN + 1;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_CMP  = 4'd10
  } alu_op_e;

endpackage

// File: rtl/exu_alu_rr_pick.sv
// exu_alu_rr_pick: combinational circular first-one picker.
// Returns the first set bit of valid at or after ptr, wrapping around.
// Ports:
//   valid  in  N      candidate vector
//   ptr    in  IDX_W  search start index (must be < N)
//   grant  out N      one-hot on the picked index, zero if none
//   idx    out IDX_W  picked index, zero if none
//   found  out 1      some candidate was picked
module exu_alu_rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = IDX_W'((int'(ptr) + i) % N);
      if (!found && valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/exu_alu_arb.sv
// exu_alu_arb: shares the combinational ALU between N_REQ requesters.
// Picks one valid requester per cycle (round-robin), encodes its op onto
// the ALU info buses (unused buses zero) and registers the ALU result in
// a one-entry response slot with a valid/ready handshake.
// Optional: define EXU_ALU_ARB_PRIO0_EN to give requester 0 strict
// priority; the others then round-robin among themselves.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req_valid/o_req_ready  per-requester handshake (ready one-hot or 0)
//   i_req_op/rs1/rs2      packed per-requester op and operands
//   o_*_info              ALU function info buses
//   i_alu_result/i_alu_cmp   ALU result and flags {lt, ltu, eq}
//   o_rsp_valid/i_rsp_ready  response slot handshake
//   o_rsp_id/result/cmp   registered response
module exu_alu_arb
  import exu_alu_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int ID_W  = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_REQ-1:0]        i_req_valid,
  output logic [N_REQ-1:0]        o_req_ready,
  input  logic [4*N_REQ-1:0]      i_req_op,
  input  logic [XLEN*N_REQ-1:0]   i_req_rs1,
  input  logic [XLEN*N_REQ-1:0]   i_req_rs2,
  output logic [ADD_INFO_W-1:0]   o_add_info,
  output logic [LOG_INFO_W-1:0]   o_or_info,
  output logic [LOG_INFO_W-1:0]   o_xor_info,
  output logic [LOG_INFO_W-1:0]   o_and_info,
  output logic [SHF_INFO_W-1:0]   o_sll_info,
  output logic [SHF_INFO_W-1:0]   o_srl_info,
  output logic [SHF_INFO_W-1:0]   o_sra_info,
  output logic [SLT_INFO_W-1:0]   o_slt_info,
  output logic [SLT_INFO_W-1:0]   o_sltu_info,
  input  logic [XLEN-1:0]         i_alu_result,
  input  logic [2:0]              i_alu_cmp,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [ID_W-1:0]         o_rsp_id,
  output logic [XLEN-1:0]         o_rsp_result,
  output logic [2:0]              o_rsp_cmp
);

  logic [ID_W-1:0]  rr_ptr;
  logic             can_accept;
  logic [N_REQ-1:0] pick_valid;
  logic [N_REQ-1:0] pick_grant;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_found;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic             fire;
  logic             rr_adv;
  logic [ID_W-1:0]  rr_next;

  logic [3:0]      op_a  [N_REQ];
  logic [XLEN-1:0] rs1_a [N_REQ];
  logic [XLEN-1:0] rs2_a [N_REQ];
  alu_op_e         sel_op;
  logic [XLEN-1:0] sel_rs1;
  logic [XLEN-1:0] sel_rs2;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign op_a[g]  = i_req_op[4*g +: 4];
    assign rs1_a[g] = i_req_rs1[XLEN*g +: XLEN];
    assign rs2_a[g] = i_req_rs2[XLEN*g +: XLEN];
  end

  assign can_accept = !o_rsp_valid || i_rsp_ready;

`ifdef EXU_ALU_ARB_PRIO0_EN
  // Requester 0 bypasses the rotation, so the picker only sees 1..N_REQ-1.
  assign pick_valid = i_req_valid & ~N_REQ'(1);
`else
  assign pick_valid = i_req_valid;
`endif

  exu_alu_rr_pick #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_pick (
    .valid (pick_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    fire    = 1'b0;
    if (can_accept && !i_rst) begin
`ifdef EXU_ALU_ARB_PRIO0_EN
      if (i_req_valid[0]) begin
        gnt[0] = 1'b1;
        fire   = 1'b1;
      end else
`endif
      if (pick_found) begin
        gnt     = pick_grant;
        gnt_idx = pick_idx;
        fire    = 1'b1;
      end
    end
  end

  assign o_req_ready = gnt;

  assign sel_op  = alu_op_e'(op_a[gnt_idx]);
  assign sel_rs1 = rs1_a[gnt_idx];
  assign sel_rs2 = rs2_a[gnt_idx];

  // Only the bus of the selected function is driven; the ALU ORs all
  // function results, so every other bus must stay zero.
  always_comb begin
    o_add_info  = '0;
    o_or_info   = '0;
    o_xor_info  = '0;
    o_and_info  = '0;
    o_sll_info  = '0;
    o_srl_info  = '0;
    o_sra_info  = '0;
    o_slt_info  = '0;
    o_sltu_info = '0;
    if (fire) begin
      case (sel_op)
        ALU_ADD:  o_add_info = {1'b0, sel_rs2, sel_rs1};
        ALU_SUB:  o_add_info = {1'b1, ~sel_rs2, sel_rs1};
        ALU_AND:  o_and_info = {sel_rs2, sel_rs1};
        ALU_OR:   o_or_info  = {sel_rs2, sel_rs1};
        ALU_XOR:  o_xor_info = {sel_rs2, sel_rs1};
        ALU_SLL:  o_sll_info = {sel_rs2[SHAMT_W-1:0], sel_rs1};
        ALU_SRL:  o_srl_info = {sel_rs2[SHAMT_W-1:0], sel_rs1};
        ALU_SRA:  o_sra_info = {sel_rs2[SHAMT_W-1:0], sel_rs1};
        // The unselected compare bus still carries operands (sel=0) so
        // all three flags are valid without adding to the result.
        ALU_SLT: begin
          o_slt_info  = {1'b1, sel_rs2, sel_rs1};
          o_sltu_info = {1'b0, sel_rs2, sel_rs1};
        end
        ALU_SLTU: begin
          o_slt_info  = {1'b0, sel_rs2, sel_rs1};
          o_sltu_info = {1'b1, sel_rs2, sel_rs1};
        end
        ALU_CMP: begin
          o_slt_info  = {1'b0, sel_rs2, sel_rs1};
          o_sltu_info = {1'b0, sel_rs2, sel_rs1};
        end
        default: ;
      endcase
    end
  end

  assign rr_next = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

`ifdef EXU_ALU_ARB_PRIO0_EN
  assign rr_adv = fire && (gnt_idx != '0);
`else
  assign rr_adv = fire;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr <= '0;
    end else if (rr_adv) begin
      rr_ptr <= rr_next;
    end
  end

  // A fire overwrites the slot even when it is draining this cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rsp_valid  <= 1'b0;
      o_rsp_id     <= '0;
      o_rsp_result <= '0;
      o_rsp_cmp    <= '0;
    end else if (fire) begin
      o_rsp_valid  <= 1'b1;
      o_rsp_id     <= gnt_idx;
      o_rsp_result <= i_alu_result;
      o_rsp_cmp    <= i_alu_cmp;
    end else if (i_rsp_ready) begin
      o_rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exu_alu_arb.sv
module tb_exu_alu_arb;
  import exu_alu_pkg::*;

  localparam int N = 3;
  localparam int W = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [4*N-1:0]  req_op;
  logic [32*N-1:0] req_rs1;
  logic [32*N-1:0] req_rs2;
  logic [64:0]     add_info;
  logic [63:0]     or_info, xor_info, and_info;
  logic [36:0]     sll_info, srl_info, sra_info;
  logic [64:0]     slt_info, sltu_info;
  logic [31:0]     alu_result;
  logic [2:0]      alu_cmp;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [W-1:0]    rsp_id;
  logic [31:0]     rsp_result;
  logic [2:0]      rsp_cmp;

  exu_alu_arb #(.N_REQ(N), .ID_W(W)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_op     (req_op),
    .i_req_rs1    (req_rs1),
    .i_req_rs2    (req_rs2),
    .o_add_info   (add_info),
    .o_or_info    (or_info),
    .o_xor_info   (xor_info),
    .o_and_info   (and_info),
    .o_sll_info   (sll_info),
    .o_srl_info   (srl_info),
    .o_sra_info   (sra_info),
    .o_slt_info   (slt_info),
    .o_sltu_info  (sltu_info),
    .i_alu_result (alu_result),
    .i_alu_cmp    (alu_cmp),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_id     (rsp_id),
    .o_rsp_result (rsp_result),
    .o_rsp_cmp    (rsp_cmp)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: every function result ORed, flags from the compare buses.
  always_comb begin
    alu_result = (add_info[31:0] + add_info[63:32] + {31'd0, add_info[64]})
               | (or_info[31:0] | or_info[63:32])
               | (xor_info[31:0] ^ xor_info[63:32])
               | (and_info[31:0] & and_info[63:32])
               | (sll_info[31:0] << sll_info[36:32])
               | (srl_info[31:0] >> srl_info[36:32])
               | 32'($signed(sra_info[31:0]) >>> sra_info[36:32])
               | {31'd0, slt_info[64] & ($signed(slt_info[31:0]) < $signed(slt_info[63:32]))}
               | {31'd0, sltu_info[64] & (sltu_info[31:0] < sltu_info[63:32])};
    alu_cmp = {$signed(slt_info[31:0]) < $signed(slt_info[63:32]),
               sltu_info[31:0] < sltu_info[63:32],
               sltu_info[31:0] == sltu_info[63:32]};
  end

  // Stimulus state
  logic [3:0]  op_q  [N];
  logic [31:0] rs1_q [N];
  logic [31:0] rs2_q [N];
  logic        pend  [N];
  bit          chk_sub_bus;

  // Reference model state
  int          m_ptr;
  bit          m_valid;
  int          m_id;
  logic [31:0] m_res;
  logic [2:0]  m_cmp;
  int          last_g;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << b[4:0];
      4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a >> b[4:0];
      4'd7:  return 32'($signed(a) >>> b[4:0]);
      4'd8:  return a | b;
      4'd9:  return a & b;
      default: return 32'd0;
    endcase
  endfunction

  // Compare ops report true flags; all others leave the compare buses at
  // zero, which this ALU reports as {lt=0, ltu=0, eq=1}.
  function automatic logic [2:0] ref_cmp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 4'd3 || op == 4'd4 || op == 4'd10)
      return {$signed(a) < $signed(b), a < b, a == b};
    return 3'b001;
  endfunction

  function automatic int ref_pick(input logic [N-1:0] v, input int ptr);
`ifdef EXU_ALU_ARB_PRIO0_EN
    if (v[0]) return 0;
`endif
    for (int i = 0; i < N; i++) begin
      int j;
      j = (ptr + i) % N;
`ifdef EXU_ALU_ARB_PRIO0_EN
      if (j == 0) continue;
`endif
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // One clock: inputs are applied just after a falling edge, ready and the
  // info buses are checked before the rising edge, the slot just after it.
  task automatic step(input string tag);
    int          g;
    logic [N-1:0] exp_rdy;
    logic [31:0] e_res;
    logic [2:0]  e_cmp;
    for (int i = 0; i < N; i++) begin
      req_op[4*i +: 4]   = op_q[i];
      req_rs1[32*i +: 32] = rs1_q[i];
      req_rs2[32*i +: 32] = rs2_q[i];
    end
    #1;
    g = -1;
    if (!rst && (!m_valid || rsp_ready)) g = ref_pick(req_valid, m_ptr);
    exp_rdy = (g >= 0) ? N'(1 << g) : '0;
    chk({tag, " ready"}, 65'(req_ready), 65'(exp_rdy));
    e_res = 32'd0;
    e_cmp = 3'd0;
    if (g >= 0) begin
      e_res = ref_res(op_q[g], rs1_q[g], rs2_q[g]);
      e_cmp = ref_cmp(op_q[g], rs1_q[g], rs2_q[g]);
    end
    if (chk_sub_bus && g >= 0) begin
      chk({tag, " add_bus"}, add_info, {1'b1, ~rs2_q[g], rs1_q[g]});
      chk({tag, " other_bus"}, 65'(or_info | xor_info | and_info | 64'(sll_info) | 64'(srl_info)
                                   | 64'(sra_info) | slt_info[63:0] | sltu_info[63:0])
                                   | {slt_info[64] | sltu_info[64], 64'd0}, 65'd0);
    end
    @(posedge clk);
    #1;
    last_g = -1;
    if (rst) begin
      m_valid = 1'b0; m_ptr = 0; m_id = 0; m_res = '0; m_cmp = '0;
    end else if (g >= 0) begin
      m_valid = 1'b1; m_id = g; m_res = e_res; m_cmp = e_cmp;
      last_g = g;
`ifdef EXU_ALU_ARB_PRIO0_EN
      if (g != 0) m_ptr = (g + 1) % N;
`else
      m_ptr = (g + 1) % N;
`endif
    end else if (m_valid && rsp_ready) begin
      m_valid = 1'b0;
    end
    chk({tag, " rsp_valid"}, 65'(rsp_valid), 65'(m_valid));
    if (m_valid || rst) begin
      chk({tag, " rsp_id"}, 65'(rsp_id), 65'(m_id));
      chk({tag, " rsp_result"}, 65'(rsp_result), 65'(m_res));
      chk({tag, " rsp_cmp"}, 65'(rsp_cmp), 65'(m_cmp));
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    op_q[r] = op; rs1_q[r] = a; rs2_q[r] = b;
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b0; req_valid = '0; chk_sub_bus = 1'b0;
    m_ptr = 0; m_valid = 1'b0; m_id = 0; m_res = '0; m_cmp = '0; last_g = -1;
    for (int i = 0; i < N; i++) begin set_req(i, 4'd0, 32'd0, 32'd0); pend[i] = 1'b0; end
    @(negedge clk);

    // Reset, with a request present that must not fire
    step("reset0");
    req_valid = 3'b011;
    step("reset1");
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;

    // Single SUB from requester 1
    set_req(1, 4'd1, 32'd5, 32'd7);
    req_valid = 3'b010;
    chk_sub_bus = 1'b1;
    step("sub");
    chk_sub_bus = 1'b0;
    chk("sub id", 65'(rsp_id), 65'd1);
    chk("sub result", 65'(rsp_result), 65'h0FFFFFFFE);
    req_valid = '0;
    step("sub_drain");

    // Round-robin with all three valid
    set_req(0, 4'd0, 32'd10, 32'd1);
    set_req(1, 4'd8, 32'hF0, 32'h0F);
    set_req(2, 4'd2, 32'd3, 32'd4);
    req_valid = 3'b111;
    for (int i = 0; i < 6; i++) step("rr");
    req_valid = '0;
    step("rr_drain");

    // Backpressure on an SRA response, then drain + fire
    set_req(0, 4'd7, 32'h8000_0000, 32'd4);
    req_valid = 3'b001;
    rsp_ready = 1'b0;
    step("sra");
    set_req(2, 4'd0, 32'd100, 32'd23);
    req_valid = 3'b100;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      chk("stall result", 65'(rsp_result), 65'h0F8000000);
    end
    rsp_ready = 1'b1;
    step("drain_fire");
    chk("drain_fire id", 65'(rsp_id), 65'd2);
    req_valid = '0;
    step("bp_idle");

    // Compare and SLTU
    set_req(0, 4'd10, 32'hFFFF_FFFF, 32'd1);
    req_valid = 3'b001;
    step("cmp");
    chk("cmp flags", 65'(rsp_cmp), 65'b100);
    chk("cmp result", 65'(rsp_result), 65'd0);
    set_req(0, 4'd4, 32'hFFFF_FFFF, 32'd1);
    step("sltu");
    chk("sltu flags", 65'(rsp_cmp), 65'b100);
    chk("sltu result", 65'(rsp_result), 65'd0);

    // Illegal op, then reset while the response is stalled
    set_req(0, 4'hF, 32'h1234, 32'h5678);
    step("illegal");
    chk("illegal result", 65'(rsp_result), 65'd0);
    req_valid = '0;
    rsp_ready = 1'b0;
    step("hold");
    rst = 1'b1;
    step("mid_rst");
    chk("mid_rst valid", 65'(rsp_valid), 65'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 4'd5, 32'(i), 32'hFF);
    req_valid = 3'b111;
    step("post_rst");
    chk("post_rst grant", 65'(rsp_id), 65'd0);

`ifdef EXU_ALU_ARB_PRIO0_EN
    req_valid = 3'b101;
    for (int i = 0; i < 4; i++) begin
      step("prio0");
      chk("prio0 id", 65'(rsp_id), 65'd0);
    end
    req_valid = 3'b110;
    for (int i = 0; i < 4; i++) step("prio_rr");
`endif
    req_valid = '0;
    step("idle");

    // Randomised traffic; requesters hold their request until it fires
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1;
          set_req(i, 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom(),
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom());
        end
        req_valid[i] = pend[i];
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step("rand");
      if (last_g >= 0) pend[last_g] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
